seven_segment_monitor: RTL and testbench

//   Receive side of the seven-segment display interface: watches a 7-bit

---
 rtl/seven_segment_monitor.sv | 179 +++++++++++++++++
 tb/tb_seven_segment_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: receive side of a seven-segment display link.
// Samples an active-low abcdefg bus, debounces it, decodes the shown hex
// digit, flags non-glyph patterns and checks +1 mod 16 digit sequencing.
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [6:0]               abcdefg,
  output logic [3:0]               number,
  output logic                     number_valid,
  output logic                     update,
  output logic                     invalid,
  output logic                     seq_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_CYCLES);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [6:0]               sample_q;
  logic [6:0]               cand_q, cand_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               state_q, state_d;
  logic [6:0]               acc_pat_q, acc_pat_d;
  logic                     have_acc_q, have_acc_d;
  logic [3:0]               prev_q, prev_d;
  logic                     has_prev_q, has_prev_d;
  logic [3:0]               number_q, number_d;
  logic                     valid_q, valid_d;
  logic                     update_q, update_d;
  logic                     invalid_q, invalid_d;
  logic                     seq_q, seq_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  logic       accept;
  logic       glyph_ok;
  logic [3:0] glyph_digit;
  logic [3:0] prev_plus1;
  logic       err_inc;

  // Decode the sampled pattern back to a hex digit (gfedcba, active-low).
  always_comb begin
    glyph_ok    = 1'b1;
    glyph_digit = 4'h0;
    case (sample_q)
      7'h40: glyph_digit = 4'h0;
      7'h79: glyph_digit = 4'h1;
      7'h24: glyph_digit = 4'h2;
      7'h30: glyph_digit = 4'h3;
      7'h19: glyph_digit = 4'h4;
      7'h12: glyph_digit = 4'h5;
      7'h02: glyph_digit = 4'h6;
      7'h78: glyph_digit = 4'h7;
      7'h00: glyph_digit = 4'h8;
      7'h10: glyph_digit = 4'h9;
      7'h08: glyph_digit = 4'hA;
      7'h03: glyph_digit = 4'hB;
      7'h46: glyph_digit = 4'hC;
      7'h21: glyph_digit = 4'hD;
      7'h06: glyph_digit = 4'hE;
      7'h0E: glyph_digit = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Debounce: any change restarts the count; acceptance when the count hits the limit.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (sample_q != cand_q) begin
      cand_d  = sample_q;
      cnt_d   = CW'(1);
      state_d = ST_SETTLE;
      if (STABLE_LIM == CW'(1)) begin
        accept  = 1'b1;
        state_d = ST_LOCKED;
      end
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == STABLE_LIM) begin
        accept  = 1'b1;
        state_d = ST_LOCKED;
      end
    end
  end

  assign prev_plus1 = prev_q + 4'd1;

  // Act on an acceptance. A glitch shorter than the debounce window that
  // returns to the already-accepted pattern re-accepts that same pattern;
  // this is a non-event, so it produces no pulses and no error.
  always_comb begin
    acc_pat_d  = acc_pat_q;
    have_acc_d = have_acc_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    number_d   = number_q;
    valid_d    = valid_q;
    invalid_d  = invalid_q;
    update_d   = 1'b0;
    seq_d      = 1'b0;
    err_inc    = 1'b0;
    if (accept && !(have_acc_q && (sample_q == acc_pat_q))) begin
      acc_pat_d  = sample_q;
      have_acc_d = 1'b1;
      if (glyph_ok) begin
        number_d  = glyph_digit;
        valid_d   = 1'b1;
        invalid_d = 1'b0;
        update_d  = 1'b1;
        if (has_prev_q && (glyph_digit != prev_q) && (glyph_digit != prev_plus1)) begin
          seq_d   = 1'b1;
          err_inc = 1'b1;
        end
        prev_d     = glyph_digit;
        has_prev_d = 1'b1;
      end else begin
        invalid_d = 1'b1;
        valid_d   = 1'b0;
        err_inc   = 1'b1;
      end
    end
    err_d = err_q;
    if (err_inc && (err_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_CNT_WIDTH'(1);
    end
  end

  // All state registers, cleared asynchronously by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q   <= 7'h00;
      cand_q     <= 7'h00;
      cnt_q      <= '0;
      state_q    <= ST_EMPTY;
      acc_pat_q  <= 7'h00;
      have_acc_q <= 1'b0;
      prev_q     <= 4'h0;
      has_prev_q <= 1'b0;
      number_q   <= 4'h0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      invalid_q  <= 1'b0;
      seq_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      sample_q   <= abcdefg;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      acc_pat_q  <= acc_pat_d;
      have_acc_q <= have_acc_d;
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      number_q   <= number_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      invalid_q  <= invalid_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign update       = update_q;
  assign invalid      = invalid_q;
  assign seq_error    = seq_q;
  assign error_count  = err_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Bench for seven_segment_monitor: run-length reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_seven_segment_monitor;
  localparam int S = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [6:0] abcdefg = 7'h00;

  logic [3:0] number, number2;
  logic       number_valid, update, invalid, seq_error;
  logic       number_valid2, update2, invalid2, seq_error2;
  logic [7:0] error_count;
  logic [1:0] error_count2;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int seq_cnt = 0;

  seven_segment_monitor #(.STABLE_CYCLES(S), .ERR_CNT_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .abcdefg(abcdefg),
    .number(number), .number_valid(number_valid), .update(update),
    .invalid(invalid), .seq_error(seq_error), .error_count(error_count)
  );

  seven_segment_monitor #(.STABLE_CYCLES(S), .ERR_CNT_WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .abcdefg(abcdefg),
    .number(number2), .number_valid(number_valid2), .update(update2),
    .invalid(invalid2), .seq_error(seq_error2), .error_count(error_count2)
  );

  always #5 clock = ~clock;

  // Glyph table, index = digit.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: a pattern is accepted when the registered sample has
  // shown it for exactly S consecutive edges after a change.
  logic [6:0] m_sample = 7'h00, m_last = 7'h00, m_acc = 7'h00;
  int         m_run = S + 1;
  bit         m_have = 0, m_has_prev = 0;
  int         m_prev = 0, m_raw = 0;
  int         e_number = 0;
  bit         e_valid = 0, e_update = 0, e_invalid = 0, e_seq = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_sample = 7'h00; m_last = 7'h00; m_acc = 7'h00; m_run = S + 1;
      m_have = 0; m_has_prev = 0; m_prev = 0; m_raw = 0;
      e_number = 0; e_valid = 0; e_update = 0; e_invalid = 0; e_seq = 0;
    end else begin
      int d;
      e_update = 0;
      e_seq = 0;
      if (m_sample == m_last) begin
        if (m_run < S + 1) m_run++;
      end else begin
        m_last = m_sample;
        m_run = 1;
      end
      if (m_run == S && !(m_have && m_sample == m_acc)) begin
        m_have = 1;
        m_acc = m_sample;
        d = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == m_sample) d = i;
        if (d >= 0) begin
          e_number = d; e_valid = 1; e_invalid = 0; e_update = 1;
          if (m_has_prev && d != m_prev && d != (m_prev + 1) % 16) begin
            e_seq = 1;
            m_raw++;
          end
          m_prev = d;
          m_has_prev = 1;
        end else begin
          e_invalid = 1; e_valid = 0;
          m_raw++;
        end
      end
      m_sample = abcdefg;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    int e8, e2;
    e8 = (m_raw > 255) ? 255 : m_raw;
    e2 = (m_raw > 3) ? 3 : m_raw;
    chk("cyc_number", number, e_number);
    chk("cyc_valid", number_valid, e_valid);
    chk("cyc_update", update, e_update);
    chk("cyc_invalid", invalid, e_invalid);
    chk("cyc_seq", seq_error, e_seq);
    chk("cyc_err8", error_count, e8);
    chk("cyc_number2", number2, e_number);
    chk("cyc_update2", update2, e_update);
    chk("cyc_valid2", number_valid2, e_valid);
    chk("cyc_invalid2", invalid2, e_invalid);
    chk("cyc_seq2", seq_error2, e_seq);
    chk("cyc_err2", error_count2, e2);
    upd_cnt += int'(update);
    seq_cnt += int'(seq_error);
  end

  task automatic hold(input logic [6:0] pat, input int n);
    abcdefg = pat;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int u0, s0;
    #1 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // 1: latency of the first acceptance
    abcdefg = 7'h40;
    repeat (S) @(negedge clock);
    chk("t1_no_update_early", update, 0);
    @(negedge clock);
    chk("t1_update", update, 1);
    chk("t1_number", number, 0);
    chk("t1_valid", number_valid, 1);
    chk("t1_seq", seq_error, 0);
    chk("t1_err", error_count, 0);
    repeat (5) @(negedge clock);

    // 2: full counting sequence 0..F,0 from a fresh reset
    do_reset();
    u0 = upd_cnt;
    for (int i = 0; i < 17; i++) hold(glyph[i % 16], 10);
    chk("t2_updates", upd_cnt - u0, 17);
    chk("t2_seq", seq_cnt, 0);
    chk("t2_number", number, 0);
    chk("t2_err", error_count, 0);

    // 3: short glitch is filtered
    hold(7'h79, 10);
    u0 = upd_cnt;
    hold(7'h24, S - 1);
    hold(7'h79, 10);
    chk("t3_no_update", upd_cnt - u0, 0);
    chk("t3_number", number, 1);

    // 4: invalid pattern, then legal continuation
    hold(7'h7F, 10);
    chk("t4_invalid", invalid, 1);
    chk("t4_valid", number_valid, 0);
    chk("t4_number", number, 1);
    chk("t4_err", error_count, 1);
    u0 = upd_cnt;
    hold(7'h24, 10);
    chk("t4_update", upd_cnt - u0, 1);
    chk("t4_number2", number, 2);
    chk("t4_seq", seq_cnt, 0);

    // 5: sequence break, then saturation of the narrow counter
    hold(7'h30, 10);
    hold(7'h12, 10);
    chk("t5_seq", seq_cnt, 1);
    chk("t5_err", error_count, 2);
    chk("t5_number", number, 5);
    hold(7'h7F, 10);
    hold(7'h7E, 10);
    hold(7'h7D, 10);
    chk("t5_err8", error_count, 5);
    chk("t5_err2_sat", error_count2, 3);

    // 6: asynchronous reset mid-settle, then first digit is unchecked
    s0 = seq_cnt;
    hold(7'h19, 2);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_number", number, 0);
    chk("t6_valid", number_valid, 0);
    chk("t6_update", update, 0);
    chk("t6_invalid", invalid, 0);
    chk("t6_seq", seq_error, 0);
    chk("t6_err", error_count, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    hold(7'h78, 10);
    chk("t6_number7", number, 7);
    chk("t6_valid7", number_valid, 1);
    chk("t6_noseq", seq_cnt - s0, 0);
    chk("t6_err_after", error_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
